// File: rtl/freq_meter_bcd_pkg.sv
// Shared types and gate-length helper for the BCD frequency meter.
// Gate lengths are decade fractions of the range-0 gate.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    GATE
  } fm_state_t;

  localparam int BCD_W = 4;

  localparam int unsigned DECADE [10] = '{
    1, 10, 100, 1000, 10000,
    100000, 1000000, 10000000,
    100000000, 1000000000
  };

  // Only ever evaluated on constants, so no divider is built.
  function automatic int unsigned gate_len(
    input int unsigned rng,
    input int unsigned gate_cycles
  );
    return gate_cycles / DECADE[rng];
  endfunction

endpackage

// File: rtl/freq_meter_bcd_counter.sv
// Saturating ripple BCD counter: clear, inc, digits, sat.
// next_digits/next_sat expose the value after this cycle's inc.
module bcd_sat_counter
  import freq_meter_pkg::*;
#(
  parameter int DIGITS_NUM = 6
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        clear,
  input  logic                        inc,
  output logic [BCD_W*DIGITS_NUM-1:0] digits,
  output logic                        sat,
  output logic [BCD_W*DIGITS_NUM-1:0] next_digits,
  output logic                        next_sat
);

  logic             carry;
  logic             all9;
  logic [BCD_W-1:0] d;

  always_comb begin
    carry       = inc;
    all9        = 1'b1;
    d           = '0;
    next_digits = digits;
    for (int i = 0; i < DIGITS_NUM; i++) begin
      d = digits[i*BCD_W +: BCD_W];
      if (d != 4'd9) all9 = 1'b0;
      if (carry) begin
        if (d == 4'd9) begin
          next_digits[i*BCD_W +: BCD_W] = '0;
        end else begin
          next_digits[i*BCD_W +: BCD_W] = d + 4'd1;
          carry = 1'b0;
        end
      end
    end
    // At all-9s the count holds and only the flag moves.
    if (all9 && inc) next_digits = digits;
    next_sat = sat | (inc & all9);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      digits <= '0;
      sat    <= 1'b0;
    end else if (clear) begin
      digits <= '0;
      sat    <= 1'b0;
    end else begin
      digits <= next_digits;
      sat    <= next_sat;
    end
  end

endmodule

// File: rtl/freq_meter_bcd.sv
// Gated frequency meter: counts sig_in rises over back-to-back gate
// windows and publishes the count as packed BCD.
// Ports: clk_in, resetn_in (async low), enable_in, range_in, sig_in;
// digits_out, overflow_out, result_stb_out (1-cycle), busy_out.
module freq_meter_bcd
  import freq_meter_pkg::*;
#(
  parameter int DIGITS_NUM  = 6,
  parameter int GATE_CYCLES = 1000000,
  parameter int RANGES      = 3
) (
  input  logic                        clk_in,
  input  logic                        resetn_in,
  input  logic                        enable_in,
  input  logic [$clog2(RANGES)-1:0]   range_in,
  input  logic                        sig_in,
  output logic [BCD_W*DIGITS_NUM-1:0] digits_out,
  output logic                        overflow_out,
  output logic                        result_stb_out,
  output logic                        busy_out
);

  localparam int RW = $clog2(RANGES);
  localparam int TW = $clog2(GATE_CYCLES);
  localparam logic [RW-1:0] RMAX = RW'(RANGES - 1);

  if ((GATE_CYCLES % DECADE[RANGES-1]) != 0 ||
      gate_len(RANGES - 1, GATE_CYCLES) < 2) begin : g_bad_cfg
    $error("freq_meter_bcd: bad GATE_CYCLES/RANGES");
  end

  // Terminal timer value per range, all constants.
  logic [TW-1:0] last_tab [RANGES];
  for (genvar r = 0; r < RANGES; r++) begin : g_tab
    assign last_tab[r] = TW'(gate_len(r, GATE_CYCLES) - 1);
  end

  logic s1, s2, prev, rise;

  fm_state_t     state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [RW-1:0] range_q, range_nxt, range_eff;
  logic          clr, inc, publish, terminal;

  logic [BCD_W*DIGITS_NUM-1:0] count, count_nxt;
  logic                        sat, sat_nxt;

  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= sig_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise      = s2 & ~prev;
  assign range_eff = (range_in > RMAX) ? RMAX : range_in;
  assign terminal  = (state == GATE) &&
                     (timer == last_tab[range_q]);
  assign busy_out  = (state == GATE);

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    range_nxt = range_q;
    clr       = 1'b0;
    inc       = 1'b0;
    publish   = 1'b0;
    unique case (state)
      IDLE: begin
        clr = 1'b1;
        if (enable_in) state_nxt = ARM;
      end
      ARM: begin
        clr       = 1'b1;
        timer_nxt = '0;
        range_nxt = range_eff;
        state_nxt = GATE;
      end
      GATE: begin
        if (!enable_in) begin
          state_nxt = IDLE;
        end else if (terminal) begin
          // Edge at T still lands in the closing window via count_nxt.
          inc       = rise;
          publish   = 1'b1;
          clr       = 1'b1;
          timer_nxt = '0;
          range_nxt = range_eff;
        end else if (range_eff != range_q) begin
          state_nxt = ARM;
        end else begin
          inc       = rise;
          timer_nxt = timer + TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      state   <= IDLE;
      timer   <= '0;
      range_q <= '0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      range_q <= range_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      digits_out     <= '0;
      overflow_out   <= 1'b0;
      result_stb_out <= 1'b0;
    end else begin
      result_stb_out <= publish;
      if (publish) begin
        digits_out   <= count_nxt;
        overflow_out <= sat_nxt;
      end
    end
  end

  bcd_sat_counter #(
    .DIGITS_NUM (DIGITS_NUM)
  ) u_cnt (
    .clk         (clk_in),
    .resetn      (resetn_in),
    .clear       (clr),
    .inc         (inc),
    .digits      (count),
    .sat         (sat),
    .next_digits (count_nxt),
    .next_sat    (sat_nxt)
  );

endmodule

// File: tb/tb_freq_meter_bcd.sv
// Directed bench for freq_meter_bcd: two instances,
// 4 digits (a) and 2 digits (b), GATE_CYCLES=1000, RANGES=3.
module tb_freq_meter_bcd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [1:0]  rng_a = 2'd0, rng_b = 2'd0;
  logic        sig_a, sig_b;
  logic        gen_a = 1'b0, gen_b = 1'b0, man_a = 1'b0;
  logic [15:0] dig_a;
  logic [7:0]  dig_b;
  logic        ovf_a, ovf_b, stb_a, stb_b, busy_a, busy_b;
  int          per_a = 10, per_b = 4, ph_a = 0, ph_b = 0;
  int          total = 0, bad = 0;
  int          n;
  bit          got, seen;

  always #5 clk = ~clk;

  assign sig_a = (per_a != 0) ? gen_a : man_a;
  assign sig_b = (per_b != 0) ? gen_b : 1'b0;

  freq_meter_bcd #(
    .DIGITS_NUM (4), .GATE_CYCLES (1000), .RANGES (3)
  ) u_a (
    .clk_in (clk), .resetn_in (rst_n), .enable_in (en_a),
    .range_in (rng_a), .sig_in (sig_a), .digits_out (dig_a),
    .overflow_out (ovf_a), .result_stb_out (stb_a),
    .busy_out (busy_a)
  );

  freq_meter_bcd #(
    .DIGITS_NUM (2), .GATE_CYCLES (1000), .RANGES (3)
  ) u_b (
    .clk_in (clk), .resetn_in (rst_n), .enable_in (en_b),
    .range_in (rng_b), .sig_in (sig_b), .digits_out (dig_b),
    .overflow_out (ovf_b), .result_stb_out (stb_b),
    .busy_out (busy_b)
  );

  // Periodic sources: high for per/2 cycles, rise once per period.
  initial begin
    forever begin
      @(negedge clk);
      if (per_a != 0) begin
        ph_a  = (ph_a + 1 >= per_a) ? 0 : ph_a + 1;
        gen_a = (ph_a < per_a / 2);
      end
      if (per_b != 0) begin
        ph_b  = (ph_b + 1 >= per_b) ? 0 : ph_b + 1;
        gen_b = (ph_b < per_b / 2);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_stb(input bit b, input int budget,
                          output int cnt, output bit hit);
    cnt = 0;
    hit = 1'b0;
    while (!hit && cnt < budget) begin
      @(negedge clk);
      cnt++;
      hit = b ? stb_b : stb_a;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_dig", dig_a, 16'h0000);
    chk("rst_ovf", ovf_a, 1'b0);
    chk("rst_stb", stb_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_dig_b", dig_b, 8'h00);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Range 0, period 10: 100 rises per 1000-cycle window.
    en_a = 1'b1;
    wait_stb(0, 1100, n, got);
    chk("r0_stb1", got, 1'b1);
    chk("r0_dig1", dig_a, 16'h0100);
    chk("r0_ovf1", ovf_a, 1'b0);
    @(negedge clk);
    chk("r0_stb_pulse", stb_a, 1'b0);
    wait_stb(0, 1100, n, got);
    chk("r0_interval", n, 999);
    chk("r0_dig2", dig_a, 16'h0100);

    // Range change at timer 499: abort, ARM, 100-cycle gate.
    repeat (499) @(negedge clk);
    rng_a = 2'd1;
    seen  = 1'b0;
    repeat (101) begin
      @(negedge clk);
      if (stb_a) seen = 1'b1;
    end
    chk("chg_no_stb", seen, 1'b0);
    chk("chg_hold", dig_a, 16'h0100);
    @(negedge clk);
    chk("chg_stb", stb_a, 1'b1);
    chk("r1_dig1", dig_a, 16'h0010);
    wait_stb(0, 200, n, got);
    chk("r1_interval", n, 100);
    chk("r1_dig2", dig_a, 16'h0010);

    // Range 2: 10-cycle gate, one rise.
    rng_a = 2'd2;
    wait_stb(0, 200, n, got);
    chk("r2_stb", got, 1'b1);
    chk("r2_dig1", dig_a, 16'h0001);
    wait_stb(0, 200, n, got);
    chk("r2_interval", n, 10);

    // Out-of-range select behaves as range 2, no abort.
    rng_a = 2'd3;
    wait_stb(0, 200, n, got);
    chk("r3_interval", n, 10);
    chk("r3_dig", dig_a, 16'h0001);

    rng_a = 2'd0;
    wait_stb(0, 1200, n, got);
    wait_stb(0, 1200, n, got);
    chk("r0b_dig", dig_a, 16'h0100);

    // Single pulses placed so detection falls at T-1, T, T+1.
    rng_a = 2'd1;
    man_a = 1'b0;
    per_a = 0;
    wait_stb(0, 300, n, got);
    wait_stb(0, 300, n, got);
    wait_stb(0, 300, n, got);
    chk("quiet_dig", dig_a, 16'h0000);
    for (int k = 96; k <= 98; k++) begin
      repeat (k) @(negedge clk);
      man_a = 1'b1;
      @(negedge clk);
      man_a = 1'b0;
      wait_stb(0, 300, n, got);
      chk($sformatf("edge_close_k%0d", k), dig_a,
          (k <= 97) ? 16'h0001 : 16'h0000);
      wait_stb(0, 300, n, got);
      chk($sformatf("edge_next_k%0d", k), dig_a,
          (k <= 97) ? 16'h0000 : 16'h0001);
    end

    // Saturation on 2 digits: 250 rises -> 99 + overflow.
    en_b = 1'b1;
    wait_stb(1, 1100, n, got);
    chk("sat_stb", got, 1'b1);
    chk("sat_dig", dig_b, 8'h99);
    chk("sat_ovf", ovf_b, 1'b1);
    per_b = 100;
    wait_stb(1, 1100, n, got);
    wait_stb(1, 1100, n, got);
    chk("unsat_dig", dig_b, 8'h10);
    chk("unsat_ovf", ovf_b, 1'b0);

    // Enable drop mid-window: idle, no strobe, result kept.
    rng_a = 2'd0;
    per_a = 10;
    wait_stb(0, 1200, n, got);
    wait_stb(0, 1200, n, got);
    chk("en_pre_dig", dig_a, 16'h0100);
    repeat (300) @(negedge clk);
    en_a = 1'b0;
    @(negedge clk);
    chk("en_busy", busy_a, 1'b0);
    seen = 1'b0;
    repeat (1100) begin
      @(negedge clk);
      if (stb_a) seen = 1'b1;
    end
    chk("en_no_stb", seen, 1'b0);
    chk("en_hold", dig_a, 16'h0100);

    // Reset mid-gate clears outputs at once; restart needs ARM+gate.
    per_a = 0;
    man_a = 1'b0;
    en_a  = 1'b1;
    repeat (400) @(negedge clk);
    chk("mid_busy", busy_a, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("ar_dig", dig_a, 16'h0000);
    chk("ar_ovf", ovf_a, 1'b0);
    chk("ar_stb", stb_a, 1'b0);
    chk("ar_busy", busy_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_stb(0, 1100, n, got);
    chk("ar_first_stb", n, 1002);
    chk("ar_first_dig", dig_a, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
